// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin arbiter that drives the 4:1 mux select.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: first set request starting at ptr, wrapping modulo 4.
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_REQ-1:0] rot_s;
    logic [IDX_W-1:0]   off_s;

    // Rotate so ptr sits at bit 0, find the first set bit, then rotate the offset back
    always_comb begin
        rot_s = {req[ptr + 2'd3], req[ptr + 2'd2], req[ptr + 2'd1], req[ptr]};
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        found  = |rot_s;
        winner = ptr + off_s;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with hold timeout; drives one-hot grant and the mux select pins.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               address0,
    output logic               address1,
    output logic               busy
);

    arb_state_t         state_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   owner_r;
    logic [CNT_W-1:0]   hold_cnt_r;
    logic [NUM_REQ-1:0] grant_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] pick_req_s;
    logic [IDX_W-1:0]   pick_ptr_s;
    logic               found_s;
    logic [IDX_W-1:0]   winner_s;
    logic               hold_last_s;

    // One picker serves both cases: idle search from ptr, handoff search from owner+1 excluding the owner
    always_comb begin
        pick_req_s  = req & ~grant_r;
        hold_last_s = (hold_cnt_r == CNT_W'(MAX_HOLD - 1));
        if (state_r == GRANT) begin
            pick_ptr_s = owner_r + 2'd1;
        end else begin
            pick_ptr_s = ptr_r;
        end
    end

    rr_priority_pick u_pick (
        .req    (pick_req_s),
        .ptr    (pick_ptr_s),
        .found  (found_s),
        .winner (winner_s)
    );

    // Arbitration state machine; owner_r doubles as the mux select and holds it while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            ptr_r      <= 2'd0;
            owner_r    <= 2'd0;
            hold_cnt_r <= '0;
            grant_r    <= 4'b0000;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    hold_cnt_r <= '0;
                    if (found_s) begin
                        state_r <= GRANT;
                        owner_r <= winner_s;
                        grant_r <= idx_to_onehot(winner_s);
                        busy_r  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!req[owner_r]) begin
                        ptr_r      <= owner_r + 2'd1;
                        hold_cnt_r <= '0;
                        if (found_s) begin
                            owner_r <= winner_s;
                            grant_r <= idx_to_onehot(winner_s);
                        end else begin
                            state_r <= IDLE;
                            grant_r <= 4'b0000;
                            busy_r  <= 1'b0;
                        end
                    end else if (hold_last_s) begin
                        // Forced handoff only when someone else waits; otherwise the tenure restarts
                        hold_cnt_r <= '0;
                        if (found_s) begin
                            ptr_r   <= owner_r + 2'd1;
                            owner_r <= winner_s;
                            grant_r <= idx_to_onehot(winner_s);
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    hold_cnt_r <= '0;
                    grant_r    <= 4'b0000;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_r;
    assign address0 = owner_r[0];
    assign address1 = owner_r[1];
    assign busy     = busy_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter with a queue-based scoreboard.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       address0;
    logic       address1;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [6:0] exp_q[$];

    int m_owner = -1;
    int m_ptr   = 0;
    int m_ten   = 0;
    int m_last  = 0;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .address0 (address0),
        .address1 (address1),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got grant/a1/a0/busy=%b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [6:0] observed();
        return {grant, address1, address0, busy};
    endfunction

    // Reference model: owner tenure counted in visible cycles, at most MAX_HOLD while others wait
    always @(posedge clk) begin
        int w;
        logic [3:0] others;
        logic [3:0] g;
        logic [1:0] a;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_ten = 0; m_last = 0;
        end else if (m_owner < 0) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin m_owner = w; m_ten = 1; m_last = w; end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            w = pick(req, m_ptr);
            if (w >= 0) begin m_owner = w; m_ten = 1; m_last = w; end
            else m_owner = -1;
        end else if (m_ten == MAX_HOLD) begin
            others = req;
            others[m_owner] = 1'b0;
            w = pick(others, (m_owner + 1) % 4);
            if (w >= 0) begin
                m_ptr = (m_owner + 1) % 4; m_owner = w; m_last = w;
            end
            m_ten = 1;
        end else begin
            m_ten++;
        end
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        a = 2'(m_last);
        exp_q.push_back({g, a[1], a[0], (m_owner >= 0)});
    end

    // Monitor: compare every registered output cycle against the model
    always @(negedge clk) begin
        logic [6:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard", observed(), e);
            if (busy && !(grant[{address1, address0}] && $onehot(grant))) begin
                tests++; fails++;
                $display("FAIL onehot_addr: grant=%b address=%b%b", grant, address1, address0);
            end
        end
    end

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] r;
        reset = 1'b1;
        req   = 4'b0000;
        #2;
        chk("reset_state", observed(), 7'b0000_0_0_0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;

        // single requester, then release keeps the select
        step(4'b0100); chk("single_grant", observed(), 7'b0100_1_0_1);
        step(4'b0000); chk("single_release", observed(), 7'b0000_1_0_0);

        // asynchronous reset mid-grant
        step(4'b0100); chk("pre_reset_grant", observed(), 7'b0100_1_0_1);
        @(negedge clk); #1 reset = 1'b1;
        #1 chk("async_reset", observed(), 7'b0000_0_0_0);
        @(posedge clk); #1 chk("reset_held", observed(), 7'b0000_0_0_0);
        @(negedge clk); #1 reset = 1'b0;
        step(4'b0000); step(4'b0000);
        chk("post_reset_idle", observed(), 7'b0000_0_0_0);

        // round-robin order with back-to-back handoffs
        step(4'b1111); chk("rr_0", observed(), 7'b0001_0_0_1);
        step(4'b1111);
        step(4'b1110); chk("rr_1", observed(), 7'b0010_0_1_1);
        step(4'b1111);
        step(4'b1101); chk("rr_2", observed(), 7'b0100_1_0_1);
        step(4'b1111);
        step(4'b1011); chk("rr_3", observed(), 7'b1000_1_1_1);
        step(4'b1111);
        step(4'b0111); chk("rr_wrap", observed(), 7'b0001_0_0_1);
        step(4'b0000);

        // timeout handoff after MAX_HOLD visible cycles
        step(4'b0001); chk("to_first", observed(), 7'b0001_0_0_1);
        for (int i = 2; i <= MAX_HOLD; i++) begin
            step(4'b0101); chk("to_hold", observed(), 7'b0001_0_0_1);
        end
        step(4'b0101); chk("to_handoff", observed(), 7'b0100_1_0_1);
        step(4'b0000);

        // no contender: grant never forced away
        for (int i = 0; i < 20; i++) begin
            step(4'b0010); chk("no_contender", observed(), 7'b0010_0_1_1);
        end
        step(4'b0000);

        // owner 3 releases, ptr wraps to 0
        step(4'b1000); chk("own3", observed(), 7'b1000_1_1_1);
        step(4'b0011); chk("wrap_prio", observed(), 7'b0001_0_0_1);
        step(4'b0000);

        // random traffic with sticky requests so timeouts occur
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            step(r);
        end
        step(4'b0000); step(4'b0000);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
